// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: merges the core's imem and dmem ports onto one shared
// memory bus. New requests are arbitrated (lock, single requester, then
// round-robin or fixed priority). The owner of every accepted request is
// pushed into an in-order tag FIFO, and in-order responses are routed back
// to the port at the FIFO head.
module frv_mem_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter bit DMEM_FIRST  = 1'b1,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        imem_req,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic        imem_gnt,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic        imem_error,
    output logic [31:0] imem_rdata,

    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_gnt,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,

    output logic        mem_req,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_recv,
    output logic        mem_ack,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        spurious
);

    // Pointer and counter widths; a depth of 1 still needs a 1-bit pointer.
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [CW-1:0] C_FULL = CW'(OUTSTANDING);

    // Source tag encoding, also used for the round-robin pointer.
    localparam logic SRC_IMEM = 1'b0;
    localparam logic SRC_DMEM = 1'b1;

    typedef enum logic [1:0] {
        LK_IDLE = 2'd0,
        LK_IMEM = 2'd1,
        LK_DMEM = 2'd2
    } lock_state_t;

    // Advance a FIFO pointer, wrapping modulo OUTSTANDING (a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (OUTSTANDING == 1) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    lock_state_t          r_lock_state;
    lock_state_t          w_lock_state_nxt;
    logic                 r_rr_ptr;
    logic [OUTSTANDING-1:0] r_tag;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_spurious;

    logic                 w_lock;
    logic                 w_lock_src;
    logic                 w_conflict;
    logic                 w_sel;
    logic                 w_sel_req;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_mem_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head;
    logic                 w_own_imem;
    logic                 w_own_dmem;
    logic                 w_mem_ack;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == {CW{1'b0}});
    assign w_head  = r_tag[r_rptr];

    // Decode the lock state into an active flag and the locked source.
    always_comb begin
        w_lock     = 1'b0;
        w_lock_src = SRC_IMEM;
        case (r_lock_state)
            LK_IMEM: begin
                w_lock     = 1'b1;
                w_lock_src = SRC_IMEM;
            end
            LK_DMEM: begin
                w_lock     = 1'b1;
                w_lock_src = SRC_DMEM;
            end
            default: begin
                w_lock     = 1'b0;
                w_lock_src = SRC_IMEM;
            end
        endcase
    end

    // Source selection: a held lock wins, then a lone requester, then the conflict policy.
    always_comb begin
        w_conflict = imem_req & dmem_req;
        w_sel      = SRC_DMEM;
        if (w_lock) begin
            w_sel = w_lock_src;
        end else if (w_conflict) begin
            if (ROUND_ROBIN) begin
                w_sel = r_rr_ptr;
            end else begin
                w_sel = DMEM_FIRST ? SRC_DMEM : SRC_IMEM;
            end
        end else if (imem_req) begin
            w_sel = SRC_IMEM;
        end else begin
            w_sel = SRC_DMEM;
        end
    end

    // Request path: mux the selected port onto the bus; full blocks without looking at pops.
    always_comb begin
        w_sel_req = w_sel ? dmem_req : imem_req;
        w_mem_req = w_sel_req & ~w_full & g_resetn;
        w_push    = w_mem_req & mem_gnt;
        if (w_sel == SRC_DMEM) begin
            mem_wen   = dmem_wen;
            mem_strb  = dmem_strb;
            mem_addr  = dmem_addr;
            mem_wdata = dmem_wdata;
        end else begin
            mem_wen   = imem_wen;
            mem_strb  = imem_strb;
            mem_addr  = imem_addr;
            mem_wdata = imem_wdata;
        end
        mem_req  = w_mem_req;
        imem_gnt = w_push & (w_sel == SRC_IMEM);
        dmem_gnt = w_push & (w_sel == SRC_DMEM);
    end

    // Response path: the FIFO head owns the response; an empty FIFO drains stray responses.
    always_comb begin
        w_own_imem = ~w_empty & (w_head == SRC_IMEM);
        w_own_dmem = ~w_empty & (w_head == SRC_DMEM);
        imem_recv  = mem_recv & w_own_imem;
        dmem_recv  = mem_recv & w_own_dmem;
        imem_error = w_own_imem ? mem_error : 1'b0;
        dmem_error = w_own_dmem ? mem_error : 1'b0;
        imem_rdata = w_own_imem ? mem_rdata : 32'h0000_0000;
        dmem_rdata = w_own_dmem ? mem_rdata : 32'h0000_0000;
        if (w_empty) begin
            w_mem_ack = mem_recv;
        end else if (w_own_dmem) begin
            w_mem_ack = dmem_ack;
        end else begin
            w_mem_ack = imem_ack;
        end
        mem_ack = w_mem_ack;
        w_pop   = mem_recv & w_mem_ack & ~w_empty;
    end

    // Lock next-state: hold a stalled request until accepted, release if its requester gives up.
    always_comb begin
        w_lock_state_nxt = r_lock_state;
        if (w_push) begin
            w_lock_state_nxt = LK_IDLE;
        end else if (w_mem_req) begin
            w_lock_state_nxt = (w_sel == SRC_DMEM) ? LK_DMEM : LK_IMEM;
        end else if (!w_sel_req) begin
            w_lock_state_nxt = LK_IDLE;
        end else begin
            w_lock_state_nxt = r_lock_state;
        end
    end

    // Lock state register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_lock_state <= LK_IDLE;
        end else begin
            r_lock_state <= w_lock_state_nxt;
        end
    end

    // Round-robin pointer: after a contested acceptance, favour the port that lost.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_rr_ptr <= SRC_DMEM;
        end else if (w_push && w_conflict) begin
            r_rr_ptr <= ~w_sel;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // In-order tag FIFO recording the owner of every accepted request.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_tag   <= {OUTSTANDING{1'b0}};
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_sel;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for responses that arrived with nothing outstanding.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_spurious <= 1'b0;
        end else if (mem_recv && w_empty) begin
            r_spurious <= 1'b1;
        end else begin
            r_spurious <= r_spurious;
        end
    end

    assign busy     = ~w_empty | w_lock;
    assign spurious = r_spurious;

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Testbench for frv_mem_arbiter: hand-derived vector table, directed
// spurious/reset sequence, and randomized traffic against a queue-based model.
module tb_frv_mem_arbiter;

    localparam int OUTSTANDING = 2;
    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        imem_req, imem_wen, imem_gnt, imem_recv, imem_ack, imem_error;
    logic [3:0]  imem_strb;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_ack, mem_error;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, spurious;

    frv_mem_arbiter #(.OUTSTANDING(OUTSTANDING), .DMEM_FIRST(1'b1), .ROUND_ROBIN(1'b1)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_gnt(imem_gnt), .imem_recv(imem_recv), .imem_ack(imem_ack),
        .imem_error(imem_error), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_recv(dmem_recv), .dmem_ack(dmem_ack),
        .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_recv(mem_recv), .mem_ack(mem_ack),
        .mem_error(mem_error), .mem_rdata(mem_rdata),
        .busy(busy), .spurious(spurious)
    );

    always #5 g_clk = ~g_clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: outstanding owners in order (0=imem, 1=dmem).
    bit m_q[$];
    bit m_lk, m_lks, m_rr, m_spur;
    bit e_full, e_empty, e_sel, e_sreq, e_mreq, e_igt, e_dgt, e_own_i, e_own_d, e_mack;

    typedef struct {
        logic ireq, dreq, mgnt, mrecv, iack, dack, merr;
        logic [31:0] rdata;
        logic igt, dgt, irecv, drecv, ierr;
        logic [31:0] irdata, drdata;
        logic mreq, mack, busy;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function void model_reset();
        m_q.delete();
        m_lk = 1'b0; m_lks = 1'b0; m_rr = 1'b1; m_spur = 1'b0;
    endfunction

    function void model_eval();
        e_full  = (m_q.size() == OUTSTANDING);
        e_empty = (m_q.size() == 0);
        if (m_lk) e_sel = m_lks;
        else if (imem_req && dmem_req) e_sel = m_rr;
        else e_sel = dmem_req;
        e_sreq  = e_sel ? dmem_req : imem_req;
        e_mreq  = e_sreq && !e_full && (g_resetn == 1'b1);
        e_igt   = e_mreq && mem_gnt && !e_sel;
        e_dgt   = e_mreq && mem_gnt && e_sel;
        e_own_i = 1'b0;
        e_own_d = 1'b0;
        if (!e_empty) begin
            e_own_i = (m_q[0] == 1'b0);
            e_own_d = (m_q[0] == 1'b1);
        end
        e_mack = e_empty ? mem_recv : (e_own_d ? dmem_ack : imem_ack);
    endfunction

    task automatic check_model();
        model_eval();
        chk("req_gnt", {mem_req, imem_gnt, dmem_gnt}, {e_mreq, e_igt, e_dgt});
        if (e_mreq)
            chk("req_fields", {mem_wen, mem_strb, mem_addr, mem_wdata},
                e_sel ? {dmem_wen, dmem_strb, dmem_addr, dmem_wdata}
                      : {imem_wen, imem_strb, imem_addr, imem_wdata});
        chk("resp_route", {imem_recv, dmem_recv, mem_ack},
            {mem_recv && e_own_i, mem_recv && e_own_d, e_mack});
        chk("resp_data", {imem_error, imem_rdata, dmem_error, dmem_rdata},
            {e_own_i ? mem_error : 1'b0, e_own_i ? mem_rdata : 32'h0,
             e_own_d ? mem_error : 1'b0, e_own_d ? mem_rdata : 32'h0});
        chk("status", {busy, spurious}, {!e_empty || m_lk, m_spur});
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_clock();
        bit acc, pop;
        model_eval();
        if (!g_resetn) begin
            model_reset();
        end else begin
            acc = e_mreq && mem_gnt;
            pop = mem_recv && e_mack && !e_empty;
            if (mem_recv && e_empty) m_spur = 1'b1;
            if (acc && imem_req && dmem_req) m_rr = !e_sel;
            if (acc) m_lk = 1'b0;
            else if (e_mreq) begin m_lk = 1'b1; m_lks = e_sel; end
            else if (m_lk && !e_sreq) m_lk = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(e_sel);
        end
    endtask

    task automatic tick();
        #3;
        check_model();
        @(posedge g_clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        imem_req = 0; imem_wen = 0; imem_strb = 4'h0; imem_addr = IA; imem_wdata = 32'h0; imem_ack = 0;
        dmem_req = 0; dmem_wen = 0; dmem_strb = 4'h0; dmem_addr = DA; dmem_wdata = 32'h0; dmem_ack = 0;
        mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = 32'h0;
    endtask

    initial begin
        // {ireq,dreq,mgnt,mrecv,iack,dack,merr,rdata, igt,dgt,irecv,drecv,ierr,irdata,drdata,mreq,mack,busy,addr}
        tbl[0]  = '{1,0,1,0,0,0,0,32'h0,        1,0,0,0,0,32'h0,32'h0,        1,0,0,IA};
        tbl[1]  = '{0,0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        0,0,1,32'h0};
        tbl[2]  = '{0,0,0,1,1,0,0,32'hDEADBEEF, 0,0,1,0,0,32'hDEADBEEF,32'h0, 0,1,1,32'h0};
        tbl[3]  = '{0,0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        0,0,0,32'h0};
        tbl[4]  = '{1,1,1,0,0,0,0,32'h0,        0,1,0,0,0,32'h0,32'h0,        1,0,0,DA};
        tbl[5]  = '{1,1,1,1,0,1,0,32'h55,       1,0,0,1,0,32'h0,32'h55,       1,1,1,IA};
        tbl[6]  = '{1,1,1,1,1,0,0,32'h66,       0,1,1,0,0,32'h66,32'h0,       1,1,1,DA};
        tbl[7]  = '{1,1,1,1,0,1,0,32'h77,       1,0,0,1,0,32'h0,32'h77,       1,1,1,IA};
        tbl[8]  = '{0,0,0,1,1,0,0,32'h88,       0,0,1,0,0,32'h88,32'h0,       0,1,1,32'h0};
        tbl[9]  = '{0,1,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        1,0,0,DA};
        tbl[10] = '{1,1,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        1,0,1,DA};
        tbl[11] = '{1,1,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        1,0,1,DA};
        tbl[12] = '{1,1,1,0,0,0,0,32'h0,        0,1,0,0,0,32'h0,32'h0,        1,0,1,DA};
        tbl[13] = '{1,0,1,0,0,0,0,32'h0,        1,0,0,0,0,32'h0,32'h0,        1,0,1,IA};
        tbl[14] = '{1,0,1,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        0,0,1,32'h0};
        tbl[15] = '{1,0,1,1,0,1,0,32'h11,       0,0,0,1,0,32'h0,32'h11,       0,1,1,32'h0};
        tbl[16] = '{1,0,1,0,0,0,0,32'h0,        1,0,0,0,0,32'h0,32'h0,        1,0,1,IA};
        tbl[17] = '{0,0,0,1,0,0,1,32'h22,       0,0,1,0,1,32'h22,32'h0,       0,0,1,32'h0};
        tbl[18] = '{0,0,0,1,1,0,1,32'h22,       0,0,1,0,1,32'h22,32'h0,       0,1,1,32'h0};
        tbl[19] = '{0,0,0,1,1,0,0,32'h33,       0,0,1,0,0,32'h33,32'h0,       0,1,1,32'h0};
        tbl[20] = '{0,0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        0,0,0,32'h0};
        tbl[21] = '{0,1,1,0,0,0,0,32'h0,        0,1,0,0,0,32'h0,32'h0,        1,0,0,DA};
        tbl[22] = '{1,0,1,0,0,0,0,32'h0,        1,0,0,0,0,32'h0,32'h0,        1,0,1,IA};
        tbl[23] = '{0,0,0,1,0,1,0,32'h11,       0,0,0,1,0,32'h0,32'h11,       0,1,1,32'h0};
        tbl[24] = '{0,0,0,1,0,1,1,32'h22,       0,0,1,0,1,32'h22,32'h0,       0,0,1,32'h0};
        tbl[25] = '{0,0,0,1,1,0,1,32'h22,       0,0,1,0,1,32'h22,32'h0,       0,1,1,32'h0};
        tbl[26] = '{0,0,0,0,0,0,0,32'h0,        0,0,0,0,0,32'h0,32'h0,        0,0,0,32'h0};
        tbl[27] = '{0,0,0,1,0,0,0,32'h99,       0,0,0,0,0,32'h0,32'h0,        0,1,0,32'h0};

        // Reset state: outputs quiet even with requests and bus grant present.
        g_resetn = 1'b0;
        idle_inputs();
        imem_req = 1; dmem_req = 1; mem_gnt = 1;
        #2;
        chk("reset_outputs", {mem_req, imem_gnt, dmem_gnt, imem_recv, dmem_recv, busy, spurious}, 7'b0);
        idle_inputs();
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        model_reset();

        // Hand-derived vector table.
        for (int i = 0; i < 28; i++) begin
            imem_req = tbl[i].ireq; dmem_req = tbl[i].dreq; mem_gnt = tbl[i].mgnt;
            mem_recv = tbl[i].mrecv; imem_ack = tbl[i].iack; dmem_ack = tbl[i].dack;
            mem_error = tbl[i].merr; mem_rdata = tbl[i].rdata;
            #2;
            chk($sformatf("v%0d_gnt", i), {imem_gnt, dmem_gnt, mem_req}, {tbl[i].igt, tbl[i].dgt, tbl[i].mreq});
            chk($sformatf("v%0d_recv", i), {imem_recv, dmem_recv, mem_ack, busy},
                {tbl[i].irecv, tbl[i].drecv, tbl[i].mack, tbl[i].busy});
            chk($sformatf("v%0d_data", i), {imem_error, imem_rdata, dmem_rdata},
                {tbl[i].ierr, tbl[i].irdata, tbl[i].drdata});
            if (tbl[i].mreq) chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
            tick();
        end

        // Spurious flag stays set; mid-cycle reset clears everything at once.
        idle_inputs();
        chk("spur_set", spurious, 1'b1);
        imem_req = 1; mem_gnt = 1;
        tick();
        idle_inputs();
        tick();
        chk("spur_sticky", {spurious, busy}, 2'b11);
        #2;
        g_resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_spur", spurious, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick();
        g_resetn = 1'b1;
        mem_recv = 1; mem_rdata = 32'hABCD_0123;
        tick();
        idle_inputs();
        #1;
        chk("drain_after_reset", spurious, 1'b1);
        tick();

        // Randomized traffic against the model, with one mid-run reset.
        for (int c = 0; c < 1500; c++) begin
            imem_req   = ($urandom_range(0, 2) != 0);
            dmem_req   = ($urandom_range(0, 2) != 0);
            imem_wen   = $urandom_range(0, 1);
            dmem_wen   = $urandom_range(0, 1);
            imem_strb  = 4'($urandom);
            dmem_strb  = 4'($urandom);
            imem_addr  = $urandom;
            dmem_addr  = $urandom;
            imem_wdata = $urandom;
            dmem_wdata = $urandom;
            mem_gnt    = $urandom_range(0, 1);
            mem_recv   = ($urandom_range(0, 2) == 0);
            imem_ack   = ($urandom_range(0, 2) != 0);
            dmem_ack   = ($urandom_range(0, 2) != 0);
            mem_error  = $urandom_range(0, 1);
            mem_rdata  = $urandom;
            if (c == 700) begin
                g_resetn = 1'b0;
                model_reset();
            end else if (c == 702) begin
                g_resetn = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frv_mem_arbiter.md
Name: frv_mem_arbiter

Overview:
- Sits directly downstream of the core's imem_* and dmem_* ports and merges them onto one shared memory bus port (mem_*).
- Arbitrates new requests between the two ports and records the owner of every accepted request in an in-order tag FIFO.
- Routes each in-order response back to the port that issued it.
- All three ports use the core's req/gnt request phase and recv/ack response phase.

Parameters:
- OUTSTANDING, 2: maximum accepted-but-unanswered transactions; tag FIFO depth, power of two, ≥1.
- DMEM_FIRST, 1: on a simultaneous imem/dmem request with no active lock and round-robin disabled, dmem wins.
- ROUND_ROBIN, 1: if 1, conflicts alternate between ports starting with dmem; DMEM_FIRST is then ignored.

Ports:
- g_clk in 1: global clock
- g_resetn in 1: asynchronous active-low reset
- imem_req, imem_wen in 1: imem request, write enable
- imem_strb in 4: write strobe
- imem_addr, imem_wdata in 32: address, write data
- imem_gnt out 1: imem request accepted
- imem_recv out 1: imem response valid
- imem_ack in 1: core accepts imem response
- imem_error out 1: response error
- imem_rdata out 32: response read data
- dmem_req, dmem_wen, dmem_strb, dmem_addr, dmem_wdata, dmem_gnt, dmem_recv, dmem_ack, dmem_error, dmem_rdata: same as imem_*, for the data port
- mem_req, mem_wen out 1: shared bus request, write enable
- mem_strb out 4: write strobe
- mem_addr, mem_wdata out 32: address, write data
- mem_gnt in 1: bus accepts request
- mem_recv in 1: bus response valid
- mem_ack out 1: arbiter accepts response
- mem_error in 1: response error
- mem_rdata in 32: response read data
- busy out 1: FIFO non-empty or lock active
- spurious out 1: sticky flag; a response arrived with the FIFO empty

Behaviour:
- Reset (async, g_resetn=0):
  - FIFO empty, lock clear, round-robin pointer = dmem, spurious=0.
  - All gnt, recv and mem_req outputs 0.
- Selection:
  - If lock is set, sel = locked source.
  - Else if only one port requests, sel = that port.
  - Else resolve by ROUND_ROBIN / DMEM_FIRST.
  - sel is valid only when some request is present.
- Request path (combinational):
  - mem_req = sel_req & !full.
  - mem_wen, mem_strb, mem_addr, mem_wdata are muxed from sel.
  - sel_gnt = mem_gnt & mem_req; the non-selected port's gnt = 0.
  - The request is zero-latency: gnt in the same cycle as mem_gnt.
- Lock:
  - Set when mem_req=1 and mem_gnt=0; records sel.
  - Cleared on the cycle the request is accepted.
  - Keeps the downstream request stable; the other port cannot preempt.
- Round-robin pointer: toggles to the non-granted port on each accepted request that won a conflict.
- Push: on acceptance (mem_req & mem_gnt), push source tag (0=imem, 1=dmem).
- Full:
  - count == OUTSTANDING forces mem_req=0 and both gnt=0.
  - This holds even if a pop occurs in the same cycle. Conservative, with no combinational pop-to-gnt path.
- Response routing (head tag = owner):
  - Owner's recv = mem_recv & !empty; its error and rdata pass mem_error and mem_rdata.
  - Non-owner's recv = 0, its rdata = 0.
  - mem_ack = owner's ack.
  - Response latency is zero added cycles.
- Pop: on mem_recv & mem_ack with FIFO non-empty.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo OUTSTANDING.
- Empty FIFO with mem_recv=1:
  - mem_ack=1 (drain), no port recv, spurious set until reset.
- Mid-operation reset:
  - All state is discarded immediately.
  - Outstanding bus responses arriving after reset are drained as spurious.
- busy = !empty | lock.

Test Plan:
- Single imem read, mem_gnt=1, response 2 cycles later with rdata=0xDEADBEEF, imem_ack=1:
  - imem_gnt same cycle; imem_recv with 0xDEADBEEF; dmem_recv=0; FIFO returns empty.
- Simultaneous requests, ROUND_ROBIN=1, mem_gnt=1 for 4 cycles:
  - Grants in order dmem, imem, dmem, imem (with OUTSTANDING=4 so the FIFO does not fill).
- dmem request with mem_gnt=0 for 3 cycles, imem requesting from cycle 1:
  - mem_addr stays the dmem address throughout; dmem granted at cycle 3; imem granted afterwards.
- OUTSTANDING=2, two imem requests accepted, no responses:
  - A third request sees mem_req=0 and imem_gnt=0.
  - After the first response pops, the request is granted the following cycle.
- Accept dmem then imem, respond 0x11 then 0x22 with mem_error on the second:
  - dmem_rdata=0x11; then imem_rdata=0x22 with imem_error=1.
  - Response held while imem_ack=0; pop occurs only on ack.
- mem_recv=1 with the FIFO empty:
  - mem_ack=1, no port recv, spurious=1 persisting.
  - Assert g_resetn=0 mid-cycle: spurious=0 and busy=0 immediately.
